// File: rtl/piso_shifter.sv
// piso_shifter: parallel-in / serial-out shifter with a one-entry shadow buffer.
//
// A word is accepted on rd_en & read_ready. It goes into the shifter when the
// shifter is idle, or when the shifter is presenting its eof beat and the
// shadow is empty. Otherwise it waits in the shadow. The shifter then emits it
// LANES bits per cycle over WIDTH/LANES beats. While rd_en is held high,
// consecutive words follow each other with no idle cycle between them.
//
// Optional feature (macro PISO_PARITY_EN): appends one even-parity beat per
// word. On lane k this beat carries the XOR of every bit sent on lane k for that
// word, and eof moves from the last data beat to the parity beat.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   rd_en      load request
//   data_in    parallel word, sampled on accept
//   flush      synchronous discard of shifter and shadow contents
//   data_out   serial beat, LANES bits wide
//   data_valid data_out carries a beat
//   read_ready shadow buffer empty (a word can be accepted)
//   sof / eof  first / last beat of a word
//   word_cnt   count of completed words, wraps at 2^CNT_W
//
// State table:
//   ST_IDLE  | shifter empty, outputs idle
//   ST_SHIFT | shifter presenting a beat of the active word
module piso_shifter #(
  parameter int WIDTH     = 32,
  parameter int LANES     = 1,
  parameter bit MSB_FIRST = 1'b0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             flush,
  output logic [LANES-1:0] data_out,
  output logic             data_valid,
  output logic             read_ready,
  output logic             sof,
  output logic             eof,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int BEATS = WIDTH / LANES;
`ifdef PISO_PARITY_EN
  localparam int LAST = BEATS;
`else
  localparam int LAST = BEATS - 1;
`endif
  localparam int RW = (LAST > 0) ? $clog2(LAST + 1) : 1;

  if (WIDTH % LANES != 0) begin : g_bad_lanes
    $error("piso_shifter: WIDTH must be a multiple of LANES");
  end

  typedef enum logic {ST_IDLE, ST_SHIFT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             shadow_full_q, shadow_full_d;
  logic [LANES-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             sof_q, sof_d;
  logic             eof_q, eof_d;
  logic             rdy_q, rdy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef PISO_PARITY_EN
  logic [LANES-1:0] par_q, par_d;
`endif

  logic             accept;
  logic             shifter_free;
  logic             do_load;
  logic [WIDTH-1:0] load_w;
  logic [WIDTH-1:0] lw;

  // Reorders the word so the shifter always emits from bit 0 upward.
  function automatic logic [WIDTH-1:0] orient(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = MSB_FIRST ? w[WIDTH-1-i] : w[i];
    end
    return r;
  endfunction

  always_comb begin
    state_d       = state_q;
    sh_d          = sh_q;
    rem_d         = rem_q;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    cnt_d         = cnt_q;
    dout_d        = '0;
    valid_d       = 1'b0;
    sof_d         = 1'b0;
    eof_d         = 1'b0;
    do_load       = 1'b0;
    load_w        = '0;
    lw            = '0;
`ifdef PISO_PARITY_EN
    par_d         = par_q;
`endif
    accept        = rd_en & rdy_q;
    // The shifter can take a new word directly once its eof beat is on the
    // output, provided nothing is already queued in the shadow.
    shifter_free  = (state_q == ST_IDLE) | (eof_q & ~shadow_full_q);

    if (flush) begin
      state_d       = ST_IDLE;
      shadow_full_d = 1'b0;
    end else begin
      if (eof_q) cnt_d = cnt_q + CNT_W'(1);

      if ((state_q == ST_SHIFT) && !eof_q) begin
        rem_d   = rem_q - RW'(1);
        eof_d   = (rem_q == RW'(1));
        valid_d = 1'b1;
`ifdef PISO_PARITY_EN
        if (rem_q == RW'(1)) begin
          dout_d = par_q;
        end else begin
          dout_d = sh_q[LANES-1:0];
          par_d  = par_q ^ sh_q[LANES-1:0];
          sh_d   = sh_q >> LANES;
        end
`else
        dout_d = sh_q[LANES-1:0];
        sh_d   = sh_q >> LANES;
`endif
      end else if (eof_q && shadow_full_q) begin
        do_load       = 1'b1;
        load_w        = shadow_q;
        shadow_full_d = 1'b0;
      end else if (accept) begin
        do_load = 1'b1;
        load_w  = data_in;
      end else begin
        state_d = ST_IDLE;
      end

      if (accept && !shifter_free) begin
        shadow_d      = data_in;
        shadow_full_d = 1'b1;
      end

      if (do_load) begin
        lw      = orient(load_w);
        state_d = ST_SHIFT;
        dout_d  = lw[LANES-1:0];
        sh_d    = lw >> LANES;
        rem_d   = RW'(LAST);
        valid_d = 1'b1;
        sof_d   = 1'b1;
        eof_d   = (LAST == 0);
`ifdef PISO_PARITY_EN
        par_d   = lw[LANES-1:0];
`endif
      end
    end

    rdy_d = ~shadow_full_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      sh_q          <= '0;
      rem_q         <= '0;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      dout_q        <= '0;
      valid_q       <= 1'b0;
      sof_q         <= 1'b0;
      eof_q         <= 1'b0;
      rdy_q         <= 1'b1;
      cnt_q         <= '0;
`ifdef PISO_PARITY_EN
      par_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      sh_q          <= sh_d;
      rem_q         <= rem_d;
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      dout_q        <= dout_d;
      valid_q       <= valid_d;
      sof_q         <= sof_d;
      eof_q         <= eof_d;
      rdy_q         <= rdy_d;
      cnt_q         <= cnt_d;
`ifdef PISO_PARITY_EN
      par_q         <= par_d;
`endif
    end
  end

  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign sof        = sof_q;
  assign eof        = eof_q;
  assign read_ready = rdy_q;
  assign word_cnt   = cnt_q;

endmodule

// File: tb/tb_piso_shifter.sv
module tb_piso_shifter;

`ifdef PISO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int BA = 32 + PAR;
  localparam int BB = 8 + PAR;
  localparam int BC = 4 + PAR;
  localparam int BD = 1 + PAR;

  typedef struct packed {
    logic [3:0] d;
    logic       sof;
    logic       eof;
  } beat_t;

  logic clk, rst;

  logic        a_rd_en, a_flush, a_dout, a_valid, a_rdy, a_sof, a_eof;
  logic [31:0] a_din;
  logic [15:0] a_cnt;
  logic        b_rd_en, b_flush, b_valid, b_rdy, b_sof, b_eof;
  logic [31:0] b_din;
  logic [3:0]  b_dout;
  logic [15:0] b_cnt;
  logic        c_rd_en, c_flush, c_valid, c_rdy, c_sof, c_eof;
  logic [7:0]  c_din;
  logic [1:0]  c_dout;
  logic [15:0] c_cnt;
  logic        d_rd_en, d_flush, d_valid, d_rdy, d_sof, d_eof;
  logic [3:0]  d_din, d_dout;
  logic [1:0]  d_cnt;

  beat_t qa[$], qb[$], qc[$], qd[$];
  int n_cmp = 0;
  int n_err = 0;
  int a_vcnt = 0;
  int v0;

  piso_shifter #(.WIDTH(32), .LANES(1), .MSB_FIRST(1'b0), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .rd_en(a_rd_en), .data_in(a_din), .flush(a_flush),
    .data_out(a_dout), .data_valid(a_valid), .read_ready(a_rdy),
    .sof(a_sof), .eof(a_eof), .word_cnt(a_cnt));

  piso_shifter #(.WIDTH(32), .LANES(4), .MSB_FIRST(1'b1), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .rd_en(b_rd_en), .data_in(b_din), .flush(b_flush),
    .data_out(b_dout), .data_valid(b_valid), .read_ready(b_rdy),
    .sof(b_sof), .eof(b_eof), .word_cnt(b_cnt));

  piso_shifter #(.WIDTH(8), .LANES(2), .MSB_FIRST(1'b0), .CNT_W(16)) u_c (
    .clk(clk), .rst(rst), .rd_en(c_rd_en), .data_in(c_din), .flush(c_flush),
    .data_out(c_dout), .data_valid(c_valid), .read_ready(c_rdy),
    .sof(c_sof), .eof(c_eof), .word_cnt(c_cnt));

  piso_shifter #(.WIDTH(4), .LANES(4), .MSB_FIRST(1'b0), .CNT_W(2)) u_d (
    .clk(clk), .rst(rst), .rd_en(d_rd_en), .data_in(d_din), .flush(d_flush),
    .data_out(d_dout), .data_valid(d_valid), .read_ready(d_rdy),
    .sof(d_sof), .eof(d_eof), .word_cnt(d_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic void qpush(input int id, input beat_t e);
    case (id)
      0: qa.push_back(e);
      1: qb.push_back(e);
      2: qc.push_back(e);
      default: qd.push_back(e);
    endcase
  endfunction

  function automatic int qsize(input int id);
    case (id)
      0: return qa.size();
      1: return qb.size();
      2: return qc.size();
      default: return qd.size();
    endcase
  endfunction

  function automatic beat_t qpop(input int id);
    case (id)
      0: return qa.pop_front();
      1: return qb.pop_front();
      2: return qc.pop_front();
      default: return qd.pop_front();
    endcase
  endfunction

  function automatic void qclear();
    qa.delete(); qb.delete(); qc.delete(); qd.delete();
  endfunction

  // hand-written beat
  function automatic void hb(input int id, input logic [3:0] d, input logic s, input logic e);
    beat_t x;
    x.d = d; x.sof = s; x.eof = e;
    qpush(id, x);
  endfunction

  // reference model: beat b, lane k carries bit j = b*L+k (or WIDTH-1-(b*L+k))
  function automatic void push_model(input int id, input logic [31:0] w,
                                     input int width, input int lanes, input bit msb);
    int beats;
    int j;
    logic [3:0] par;
    beat_t e;
    beats = width / lanes;
    par = '0;
    for (int b = 0; b < beats; b++) begin
      e = '0;
      for (int k = 0; k < lanes; k++) begin
        j = msb ? (width - 1 - (b * lanes + k)) : (b * lanes + k);
        e.d[k] = w[j];
      end
      par   = par ^ e.d;
      e.sof = (b == 0);
      e.eof = (b == beats - 1) && (PAR == 0);
      qpush(id, e);
    end
    if (PAR != 0) begin
      e = '0; e.d = par; e.eof = 1'b1;
      qpush(id, e);
    end
  endfunction

  task automatic mon(input int id, input string nm, input logic v,
                     input logic [3:0] d, input logic s, input logic e);
    beat_t act, exp;
    act = {d, s, e};
    if (v) begin
      if (qsize(id) == 0) begin
        n_cmp++; n_err++;
        $display("FAIL %s_unexpected_beat: got beat 0x%0h, expected no beat", nm, act);
      end else begin
        exp = qpop(id);
        check({nm, "_beat"}, 32'(act), 32'(exp));
      end
    end else begin
      check({nm, "_idle_zero"}, 32'(act), 32'h0);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, "a", a_valid, {3'b000, a_dout}, a_sof, a_eof);
      mon(1, "b", b_valid, b_dout, b_sof, b_eof);
      mon(2, "c", c_valid, {2'b00, c_dout}, c_sof, c_eof);
      mon(3, "d", d_valid, d_dout, d_sof, d_eof);
      if (a_valid) a_vcnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_rd_en = 0; a_flush = 0; a_din = '0;
    b_rd_en = 0; b_flush = 0; b_din = '0;
    c_rd_en = 0; c_flush = 0; c_din = '0;
    d_rd_en = 0; d_flush = 0; d_din = '0;
    #2;
    check("rst_valid", 32'(a_valid), 32'h0);
    check("rst_ready", 32'(a_rdy), 32'h1);
    check("rst_cnt", 32'(a_cnt), 32'h0);
    check("rst_dout_sof_eof", 32'({a_dout, a_sof, a_eof}), 32'h0);
    #10 rst = 1'b0;
    tick();

    // single word from idle, LSB first
    a_rd_en = 1; a_din = 32'h8000_0001;
    hb(0, 4'h1, 1, 0);
    for (int i = 0; i < 30; i++) hb(0, 4'h0, 0, 0);
    hb(0, 4'h1, 0, PAR == 0);
    if (PAR != 0) hb(0, 4'h0, 0, 1);
    tick();
    a_rd_en = 0;
    check("a_sof_first_cycle", 32'({a_valid, a_sof}), 32'h3);
    repeat (BA - 1) tick();
    check("a_eof_cycle", 32'({a_valid, a_eof}), 32'h3);
    check("a_cnt_before_end", 32'(a_cnt), 32'h0);
    tick();
    check("a_cnt_after_word", 32'(a_cnt), 32'h1);
    check("a_idle_after_word", 32'(a_valid), 32'h0);

    // three words with rd_en held high
    v0 = a_vcnt;
    a_rd_en = 1; a_din = 32'h1234_5678;
    check("a_rdy_idle", 32'(a_rdy), 32'h1);
    push_model(0, 32'h1234_5678, 32, 1, 0);
    tick();
    a_din = 32'hDEAD_BEEF;
    check("a_rdy_shifting", 32'(a_rdy), 32'h1);
    push_model(0, 32'hDEAD_BEEF, 32, 1, 0);
    tick();
    a_din = 32'h0000_FFFF;
    check("a_rdy_shadow_full", 32'(a_rdy), 32'h0);
    repeat (BA - 2) tick();
    check("a_rdy_full_at_eof", 32'(a_rdy), 32'h0);
    tick();
    check("a_rdy_after_drain", 32'(a_rdy), 32'h1);
    push_model(0, 32'h0000_FFFF, 32, 1, 0);
    tick();
    a_rd_en = 0;
    check("a_rdy_shadow_full2", 32'(a_rdy), 32'h0);
    repeat (2 * BA - 1) tick();
    check("a_contiguous_beats", 32'(a_vcnt - v0), 32'(3 * BA));
    check("a_cnt_three_more", 32'(a_cnt), 32'h4);
    check("a_idle_after_three", 32'(a_valid), 32'h0);

    // flush at beat 10 with shadow full and rd_en high
    a_rd_en = 1; a_din = 32'hCAFE_F00D;
    push_model(0, 32'hCAFE_F00D, 32, 1, 0);
    tick();
    a_din = 32'h5555_AAAA;
    push_model(0, 32'h5555_AAAA, 32, 1, 0);
    tick();
    a_din = 32'hFFFF_0000;
    repeat (9) tick();
    check("a_rdy_before_flush", 32'(a_rdy), 32'h0);
    check("a_valid_before_flush", 32'(a_valid), 32'h1);
    a_flush = 1;
    tick();
    qclear();
    a_flush = 0; a_rd_en = 0;
    check("a_flush_valid", 32'(a_valid), 32'h0);
    check("a_flush_ready", 32'(a_rdy), 32'h1);
    check("a_flush_cnt", 32'(a_cnt), 32'h4);

    // flush overrides an accept from idle
    a_rd_en = 1; a_flush = 1; a_din = 32'h1111_1111;
    tick();
    a_rd_en = 0; a_flush = 0;
    check("a_flush_drop_valid", 32'(a_valid), 32'h0);
    check("a_flush_drop_ready", 32'(a_rdy), 32'h1);

    // recovery after flush
    a_rd_en = 1; a_din = 32'h0F0F_3C3C;
    push_model(0, 32'h0F0F_3C3C, 32, 1, 0);
    tick();
    a_rd_en = 0;
    repeat (BA) tick();
    check("a_cnt_recovery", 32'(a_cnt), 32'h5);

    // 4 lanes, MSB first
    b_rd_en = 1; b_din = 32'hF0F0_0000;
    hb(1, 4'hF, 1, 0); hb(1, 4'h0, 0, 0); hb(1, 4'hF, 0, 0); hb(1, 4'h0, 0, 0);
    hb(1, 4'h0, 0, 0); hb(1, 4'h0, 0, 0); hb(1, 4'h0, 0, 0); hb(1, 4'h0, 0, PAR == 0);
    if (PAR != 0) hb(1, 4'h0, 0, 1);
    tick();
    b_rd_en = 0;
    for (int i = 0; i < BB; i++) begin
      check("b_rdy_stays_high", 32'(b_rdy), 32'h1);
      tick();
    end
    check("b_idle_after_word", 32'(b_valid), 32'h0);
    check("b_cnt_one", 32'(b_cnt), 32'h1);

    b_rd_en = 1; b_din = 32'h0123_ABCD;
    push_model(1, 32'h0123_ABCD, 32, 4, 1);
    tick();
    b_din = 32'h89AB_CDEF;
    push_model(1, 32'h89AB_CDEF, 32, 4, 1);
    tick();
    b_rd_en = 0;
    check("b_rdy_shadow_full", 32'(b_rdy), 32'h0);
    repeat (2 * BB - 1) tick();
    check("b_idle_after_two", 32'(b_valid), 32'h0);
    check("b_cnt_three", 32'(b_cnt), 32'h3);

    // 8 bits, 2 lanes
    c_rd_en = 1; c_din = 8'h07;
    hb(2, 4'h3, 1, 0); hb(2, 4'h1, 0, 0); hb(2, 4'h0, 0, 0); hb(2, 4'h0, 0, PAR == 0);
    if (PAR != 0) hb(2, 4'h2, 0, 1);
    tick();
    c_rd_en = 0;
    repeat (BC) tick();
    check("c_cnt_one", 32'(c_cnt), 32'h1);
    c_rd_en = 1; c_din = 8'hB4;
    push_model(2, 32'h0000_00B4, 8, 2, 0);
    tick();
    c_rd_en = 0;
    repeat (BC) tick();
    check("c_cnt_two", 32'(c_cnt), 32'h2);

    // one beat per word (LANES = WIDTH), 2-bit counter wrap
    d_rd_en = 1; d_din = 4'h5;
    check("d_rdy_first", 32'(d_rdy), 32'h1);
    push_model(3, 32'h5, 4, 4, 0);
    tick();
    d_din = 4'hA;
    check("d_rdy_second", 32'(d_rdy), 32'h1);
    push_model(3, 32'hA, 4, 4, 0);
    tick();
    d_rd_en = 0;
    repeat (2 * BD - 1) tick();
    check("d_idle_after_two", 32'(d_valid), 32'h0);
    check("d_cnt_two", 32'(d_cnt), 32'h2);
    d_rd_en = 1; d_din = 4'hF;
    push_model(3, 32'hF, 4, 4, 0);
    tick();
    d_rd_en = 0;
    repeat (BD) tick();
    check("d_cnt_three", 32'(d_cnt), 32'h3);
    d_rd_en = 1; d_din = 4'h1;
    push_model(3, 32'h1, 4, 4, 0);
    tick();
    d_rd_en = 0;
    repeat (BD) tick();
    check("d_cnt_wrap", 32'(d_cnt), 32'h0);

    // async reset mid-word at beat 5
    a_rd_en = 1; a_din = 32'hFFFF_FFFF;
    push_model(0, 32'hFFFF_FFFF, 32, 1, 0);
    tick();
    a_rd_en = 0;
    repeat (5) tick();
    check("a_valid_before_rst", 32'(a_valid), 32'h1);
    #2 rst = 1'b1;
    #1;
    qclear();
    check("a_rst_valid", 32'(a_valid), 32'h0);
    check("a_rst_dout_sof_eof", 32'({a_dout, a_sof, a_eof}), 32'h0);
    check("a_rst_ready", 32'(a_rdy), 32'h1);
    check("a_rst_cnt", 32'(a_cnt), 32'h0);
    tick();
    rst = 1'b0;
    repeat (40) tick();
    check("a_post_rst_valid", 32'(a_valid), 32'h0);
    check("a_post_rst_cnt", 32'(a_cnt), 32'h0);

    check("a_leftover", 32'(qsize(0)), 32'h0);
    check("b_leftover", 32'(qsize(1)), 32'h0);
    check("c_leftover", 32'(qsize(2)), 32'h0);
    check("d_leftover", 32'(qsize(3)), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/piso_shifter.md
PISO_SHIFTER -- requirements
Module: piso_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: bits per parallel word.
REQ-002 SHALL have parameter LANES, default 1: serial lanes; WIDTH mod LANES = 0, else elaboration error.
REQ-003 SHALL have parameter MSB_FIRST, default 0: 0 emits bit 0 first, 1 emits bit WIDTH-1 first.
REQ-004 SHALL have parameter CNT_W, default 16: width of word_cnt.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port rd_en  input  1  load request; word accepted when rd_en & read_ready at a rising edge.
REQ-008 SHALL have port data_in  input  WIDTH  parallel word, sampled on accept.
REQ-009 SHALL have port flush  input  1  synchronous discard of all held words.
REQ-010 SHALL have port data_out  output  LANES  serial data, one beat per cycle.
REQ-011 SHALL have port data_valid  output  1  data_out carries a beat.
REQ-012 SHALL have port read_ready  output  1  shadow buffer empty; able to accept.
REQ-013 SHALL have port sof  output  1  first beat of a word.
REQ-014 SHALL have port eof  output  1  last beat of a word.
REQ-015 SHALL have port word_cnt  output  CNT_W  completed words, wraps 2^CNT_W-1 -> 0.

Function
REQ-016 SHALL serialise each word in BEATS = WIDTH/LANES consecutive cycles (BEATS+1 with parity, REQ-030).
REQ-017 SHALL, in data beat b (0..BEATS-1), drive data_out[k] = bit j of the word with j = b*LANES+k (MSB_FIRST=0) or j = WIDTH-1-(b*LANES+k) (MSB_FIRST=1).
REQ-018 SHALL use two storage stages: shifter (active word) and one-entry shadow buffer.
REQ-019 SHALL have states IDLE (shifter empty) and SHIFT (shifter active); IDLE->SHIFT on accept; SHIFT->IDLE after eof beat when shadow empty and no accept in that cycle.
REQ-020 SHALL register all outputs; a word accepted at edge N in IDLE shows its first beat, sof=1, data_valid=1 in cycle N+1.
REQ-021 SHALL drive read_ready = 1 exactly when the shadow buffer is empty, independent of rd_en in the same cycle.
REQ-022 SHALL route an accepted word to the shifter if the shifter is empty or in its eof beat with shadow empty; otherwise to the shadow.
REQ-023 SHALL, at end of eof beat with shadow full, move the shadow word to the shifter so its sof beat follows with no idle cycle, and set read_ready=1 next cycle.
REQ-024 SHALL sustain back-to-back words with zero gap while rd_en is held high.
REQ-025 SHALL drive data_out = 0, sof = 0, eof = 0 whenever data_valid = 0.
REQ-026 SHALL assert sof and eof in the same beat when BEATS = 1 (LANES = WIDTH, parity off).
REQ-027 SHALL increment word_cnt by 1 at the edge ending each eof beat; flushed words are not counted.
REQ-028 SHALL, on flush=1 at an edge, empty shifter and shadow, go IDLE, read_ready=1, data_valid=0 next cycle; flush overrides a simultaneous rd_en (word dropped); word_cnt kept.

Reset
REQ-029 SHALL, while rst=1, asynchronously force: data_out=0, data_valid=0, sof=0, eof=0, read_ready=1, word_cnt=0, shifter and shadow empty, state IDLE; a word in flight at reset is lost with no eof.

Configuration
REQ-030 SHALL, with macro PISO_PARITY_EN defined, append one parity beat after the last data beat, data_out[k] = XOR of all bits sent on lane k for that word (even parity), with eof on the parity beat and not on the last data beat.
REQ-031 SHALL, with PISO_PARITY_EN undefined, emit exactly BEATS beats per word and contain no parity logic.

Verification
REQ-032 SHALL cover: WIDTH=32, LANES=1, MSB_FIRST=0, load 0x8000_0001 from IDLE -> beats 1,0x30,1; sof cycle N+1, eof cycle N+32; word_cnt 0->1.
REQ-033 SHALL cover: WIDTH=32, LANES=4, MSB_FIRST=1, load 0xF0F0_0000 -> 8 beats 4'hF,4'h0,4'hF,4'h0,4'h0 x4; read_ready stays 1.
REQ-034 SHALL cover: LANES=1, rd_en held high with three words -> 96 contiguous valid beats, no gap, read_ready low while shadow full, word_cnt=3.
REQ-035 SHALL cover: flush asserted at beat 10 with shadow full and rd_en=1 -> next cycle data_valid=0, read_ready=1, word_cnt unchanged.
REQ-036 SHALL cover: rst asserted mid-word at beat 5 -> outputs at reset values immediately, no eof, word_cnt=0.
REQ-037 SHALL cover: PISO_PARITY_EN, WIDTH=8, LANES=2, data 0x07 -> 5 beats, parity beat data_out=2'b10, eof on beat 5.
